// File: rtl/fpu_ss_pkg.sv
// Shared FPU-subsystem types: the X-interface id width and the metadata kept
// for each in-flight memory instruction.
package fpu_ss_pkg;

    localparam int X_ID_WIDTH = 4;

    // Metadata recorded per memory request: issuing id, FP destination, write enable.
    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [4:0]            rd;
        logic                  we;
    } mem_metadata_t;

endpackage

// File: rtl/fpu_ss_mem_tracker_if.sv
// Bundle between the FPU-subsystem controller and the memory-metadata tracker.
// The controller side is the master; the tracker itself is the slave.
interface fpu_ss_mem_tracker_if #(
    parameter int DEPTH = 2
);
    import fpu_ss_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  flush_i;
    logic                  push_valid_i;
    logic                  push_ready_o;
    mem_metadata_t         push_data_i;
    logic                  pop_valid_o;
    logic                  pop_ready_i;
    mem_metadata_t         pop_data_o;
    logic                  x_mem_result_valid_i;
    logic [X_ID_WIDTH-1:0] x_mem_result_id_i;
    logic [CNT_W-1:0]      count_o;
    logic                  underflow_o;
    logic                  id_mismatch_o;

    modport master (
        output flush_i, push_valid_i, push_data_i, pop_ready_i,
               x_mem_result_valid_i, x_mem_result_id_i,
        input  push_ready_o, pop_valid_o, pop_data_o, count_o,
               underflow_o, id_mismatch_o
    );

    modport slave (
        input  flush_i, push_valid_i, push_data_i, pop_ready_i,
               x_mem_result_valid_i, x_mem_result_id_i,
        output push_ready_o, pop_valid_o, pop_data_o, count_o,
               underflow_o, id_mismatch_o
    );

endinterface

// File: rtl/fpu_ss_mem_tracker.sv
// In-order metadata buffer for FPU memory instructions. Each accepted memory
// request pushes {id, rd, we}; each returning result pops the oldest entry.
// Results arriving while empty, or with an id other than the head's, raise
// sticky error flags that only reset clears.
module fpu_ss_mem_tracker #(
    parameter int DEPTH    = 2,
    parameter bit CHECK_ID = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    fpu_ss_mem_tracker_if.slave  bus
);
    import fpu_ss_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_metadata_t    mem_q [DEPTH];
    logic             underflow_q, underflow_d;
    logic             idMismatch_q, idMismatch_d;

    logic pushReady;
    logic popValid;
    logic doPush;
    logic doPop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign pushReady = (cnt_q != CNT_W'(DEPTH));
    assign popValid  = (cnt_q != '0);
    assign doPush    = bus.push_valid_i & pushReady;
    assign doPop     = popValid & bus.pop_ready_i;

    assign bus.push_ready_o  = pushReady;
    assign bus.pop_valid_o   = popValid;
    assign bus.pop_data_o    = popValid ? mem_q[rptr_q] : '0;
    assign bus.count_o       = cnt_q;
    assign bus.underflow_o   = underflow_q;
    assign bus.id_mismatch_o = idMismatch_q;

    // Next pointer/occupancy state; a flush wins over any same-cycle push or pop.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (bus.flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (doPush) begin
                wptr_d = ptrInc(wptr_q);
            end
            if (doPop) begin
                rptr_d = ptrInc(rptr_q);
            end
            if (doPush && !doPop) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (!doPush && doPop) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Underflow is sticky: any pop or result request while empty latches it.
    always_comb begin
        underflow_d = underflow_q;
        if (!popValid && (bus.pop_ready_i || bus.x_mem_result_valid_i)) begin
            underflow_d = 1'b1;
        end
    end

    // Result-id ordering check against the current head, removable by parameter.
    if (CHECK_ID) begin : gIdCheck
        always_comb begin
            idMismatch_d = idMismatch_q;
            if (bus.x_mem_result_valid_i && popValid &&
                (bus.x_mem_result_id_i != bus.pop_data_o.id)) begin
                idMismatch_d = 1'b1;
            end
        end
    end else begin : gNoIdCheck
        assign idMismatch_d = 1'b0;
    end

    // Control and flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            underflow_q  <= 1'b0;
            idMismatch_q <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            underflow_q  <= underflow_d;
            idMismatch_q <= idMismatch_d;
        end
    end

    // Entry storage; written only on an accepted, unflushed push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (doPush && !bus.flush_i) begin
            mem_q[wptr_q] <= bus.push_data_i;
        end
    end

endmodule

// File: doc/fpu_ss_mem_tracker.md
# fpu_ss_mem_tracker

Metadata buffer for FPU-subsystem memory instructions. It records `{id, rd, we}` for every accepted load/store memory request and holds the entries in request order. When the memory result returns, it presents the oldest entry so the controller can write back the FP register file, forward the load data and clear its scoreboards. It sits beside the controller: the controller pushes on each memory-request handshake and pops on each memory-result valid. The block also checks that results return in order and without underflow.

## Interface
Parameters:
- `DEPTH`, default 2: number of in-flight memory requests; legal range ≥1, not required to be a power of two.
- `CHECK_ID`, default 1: enables the result-id-versus-head-id check.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  synchronous clear of all entries.
- `push_valid_i`  in  1  push request.
- `push_ready_o`  out  1  space available.
- `push_data_i`  in  `mem_metadata_t`  `{id[X_ID_WIDTH-1:0], rd[4:0], we}` of the request.
- `pop_valid_o`  out  1  head entry valid.
- `pop_ready_i`  in  1  consume head.
- `pop_data_o`  out  `mem_metadata_t`  head entry.
- `x_mem_result_valid_i`  in  1  memory result returning.
- `x_mem_result_id_i`  in  `X_ID_WIDTH`  id of the returning result.
- `count_o`  out  `$clog2(DEPTH+1)`  current occupancy.
- `underflow_o`  out  1  sticky flag: result or pop arrived while empty.
- `id_mismatch_o`  out  1  sticky flag: result id differed from head id.

## Operation
- **Storage:** circular buffer of `DEPTH` entries with write pointer `wptr`, read pointer `rptr` and counter `cnt`.
  - Each pointer increments modulo `DEPTH`, wrapping from `DEPTH-1` to 0.
- **Push:** occurs when `push_valid_i & push_ready_o`.
  - Writes `push_data_i` at `wptr`, increments `wptr` and increments `cnt`.
- **Pop:** occurs when `pop_valid_o & pop_ready_i`. Increments `rptr` and decrements `cnt`.
- **Full/empty:** `push_ready_o = (cnt != DEPTH)`.
  - The ready does not depend on `pop_ready_i`, so there is no combinational path pop→push.
  - A push while full is ignored: no state change and no flag.
- **Head output:** `pop_valid_o = (cnt != 0)`; `pop_data_o` = entry at `rptr` when valid, else all-zero.
- **Simultaneous push and pop** (only possible with `cnt` ≥1): both pointers advance and `cnt` is unchanged.
  - This works at full: the pop frees a slot but the push is still refused, because ready was low.
- **Underflow:** `pop_ready_i` or `x_mem_result_valid_i` high while `cnt == 0` sets `underflow_o`. Pointers and count do not move.
- **Id check:** when `CHECK_ID=1` and `x_mem_result_valid_i & pop_valid_o & (x_mem_result_id_i != pop_data_o.id)`, set `id_mismatch_o`.
  - The head is still popped when `pop_ready_i` is high.
  - With `CHECK_ID=0`, `id_mismatch_o` is tied to 0.
- **Flush:** `flush_i` zeroes `wptr`, `rptr` and `cnt` in the next cycle.
  - Flush has priority over a same-cycle push and pop.
  - Flush does not clear the sticky flags; only reset clears them.

## Timing
- **Reset values:**
  - `push_ready_o=1`, `pop_valid_o=0`, `pop_data_o=0`, `count_o=0`, `underflow_o=0`, `id_mismatch_o=0`.
  - Pointers and storage are reset to 0.
- **Latency:** an entry pushed in cycle N is visible on `pop_valid_o`/`pop_data_o` in cycle N+1. There is no fall-through.
- **Combinational outputs:** `pop_data_o` is combinational from `rptr` and storage. All other outputs are decoded from registered state only.
- **Sticky flags:** set in the cycle after the offending event and held until `rst_ni` is asserted.
- **Reset during operation:** the asynchronous assertion immediately returns every output to its reset value. Storage contents are lost.

## Structure
- **`fpu_ss_pkg`:** `mem_metadata_t` (`id`, `rd`, `we`) and `X_ID_WIDTH` already live here and are reused unchanged.
- **Counter width:** local parameter `CNT_W = $clog2(DEPTH+1)`.
- **Pointer width:** `PTR_W = (DEPTH>1) ? $clog2(DEPTH) : 1`.
  - With `DEPTH=1` the pointers stay at 0, and full/empty are decided by `cnt` alone.
- **Sub-modules:** none; the block is a single flat module.

## Test plan
- **Reset:** hold `rst_ni=0` for 3 cycles, then release. Expect `push_ready_o=1`, `pop_valid_o=0`, `count_o=0`, both flags 0.
- **Fill/drain, `DEPTH=2`:** push id 3/rd 5/we 1, then id 7/rd 9/we 0. Expect `count_o=2` and `push_ready_o=0`.
  - A third push is ignored.
  - Result id 3 with pop gives `pop_data_o={3,5,1}`; result id 7 with pop gives `{7,9,0}`. Then `count_o=0` and no flags.
- **Simultaneous push and pop at `cnt=1`:** `count_o` stays 1 and the head advances to the new entry.
  - Repeat 5 times to exercise pointer wrap at `DEPTH=3`: the order is preserved.
- **Id mismatch:** head id 4, result id 6 with pop. Expect `id_mismatch_o=1` from the next cycle and held; `count_o` decrements.
  - Repeat with `CHECK_ID=0`: the flag stays 0.
- **Underflow:** while empty, assert `x_mem_result_valid_i` and `pop_ready_i`. Expect `underflow_o=1` next cycle, with `count_o` and pointers unchanged.
- **Flush:** with `count_o=2`, assert `flush_i` in the same cycle as a push and a pop. The next cycle shows `count_o=0`, `pop_valid_o=0`, and the flags unchanged.
